acquisition_sequencer: RTL



---
 rtl/acquisition_pkg.sv | 24 ++
 rtl/trigger_edge_detect.sv | 28 ++
 rtl/acquisition_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/acquisition_pkg.sv
// Shared definitions for the ADC acquisition sequencer.
package acquisition_pkg;

  // Default buffer address width; depth is 2**ADDR_WIDTH beats.
  localparam int unsigned DefaultAddrWidth = 12;

  // Width of the state output.
  localparam int unsigned StateWidth = 3;

  // Capture FSM encoding, visible on the state output.
  typedef enum logic [StateWidth-1:0] {
    StIdle     = 3'd0,
    StPrefill  = 3'd1,
    StWaitTrig = 3'd2,
    StPost     = 3'd3,
    StDone     = 3'd4
  } acq_state_e;

  // Beat counters need one extra bit so a full-depth count (2**aw) is representable.
  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/trigger_edge_detect.sv
// Rising-edge detector on the level trigger, merged with the software trigger pulse.
module trigger_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trigger_i,
  input  logic soft_trigger_i,
  output logic trig_event_o
);

  logic trigger_d, trigger_q;

  // Previous-cycle copy of the trigger level.
  always_comb begin
    trigger_d = trigger_i;
  end

  // Trigger history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trigger_q <= 1'b0;
    end else begin
      trigger_q <= trigger_d;
    end
  end

  assign trig_event_o = (trigger_i & ~trigger_q) | soft_trigger_i;

endmodule

// File: rtl/acquisition_sequencer.sv
// Pre/post-trigger capture controller driving the acquisition buffer write port.
module acquisition_sequencer
  import acquisition_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  adcClk,
  input  logic                  adcReset_n,
  input  logic                  armStrobe,
  input  logic                  abortStrobe,
  input  logic                  softTrigger,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] pretriggerCount,
  input  logic [ADDR_WIDTH:0]   posttriggerCount,
  input  logic                  axiValid,
  output logic                  wrEnable,
  output logic [ADDR_WIDTH-1:0] wrAddress,
  output logic [ADDR_WIDTH-1:0] triggerAddress,
  output logic [ADDR_WIDTH-1:0] startAddress,
  output logic [StateWidth-1:0] state,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntWidth = cnt_width(ADDR_WIDTH);
  localparam logic [CntWidth-1:0]   Depth   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CntWidth-1:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  acq_state_e state_d, state_q;
  logic [CntWidth-1:0]   cnt_d, cnt_q;
  logic [CntWidth-1:0]   pre_eff_d, pre_eff_q;
  logic [CntWidth-1:0]   post_eff_d, post_eff_q;
  logic [ADDR_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic [ADDR_WIDTH-1:0] trig_addr_d, trig_addr_q;
  logic [ADDR_WIDTH-1:0] start_addr_d, start_addr_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;

  logic                  trig_event;
  logic                  wr_en;
  logic [CntWidth-1:0]   cnt_inc;
  logic [CntWidth-1:0]   post_arm;
  logic [CntWidth-1:0]   pre_room;
  logic [CntWidth-1:0]   pre_ext;
  logic [CntWidth-1:0]   pre_arm;

  trigger_edge_detect u_trigger_edge_detect (
    .clk_i          (adcClk),
    .rst_ni         (adcReset_n),
    .trigger_i      (trigger),
    .soft_trigger_i (softTrigger),
    .trig_event_o   (trig_event)
  );

  // Write strobe is combinational so a beat is written in the cycle it arrives.
  assign wr_en   = axiValid & busy_q;
  assign cnt_inc = cnt_q + CntOne;

  // Effective counts latched on arm: post forced into [1, depth], pre limited to what remains.
  always_comb begin
    if (posttriggerCount == '0) begin
      post_arm = CntOne;
    end else if (posttriggerCount > Depth) begin
      post_arm = Depth;
    end else begin
      post_arm = posttriggerCount;
    end
    pre_room = Depth - post_arm;
    pre_ext  = {1'b0, pretriggerCount};
    pre_arm  = (pre_ext < pre_room) ? pre_ext : pre_room;
  end

  // Next-state logic for the capture FSM, counters and address registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pre_eff_d    = pre_eff_q;
    post_eff_d   = post_eff_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    wr_addr_d    = wr_en ? (wr_addr_q + AddrOne) : wr_addr_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (armStrobe) begin
          pre_eff_d  = pre_arm;
          post_eff_d = post_arm;
          cnt_d      = '0;
          state_d    = (pre_arm == '0) ? StWaitTrig : StPrefill;
        end
      end
      StPrefill: begin
        if (axiValid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == pre_eff_q) begin
            state_d = StWaitTrig;
          end
        end
      end
      StWaitTrig: begin
        if (trig_event) begin
          trig_addr_d  = wr_addr_q;
          start_addr_d = wr_addr_q - pre_eff_q[ADDR_WIDTH-1:0];
          // A beat in the event cycle is already the first post-trigger beat.
          cnt_d        = {{ADDR_WIDTH{1'b0}}, axiValid};
          state_d      = (axiValid && (post_eff_q == CntOne)) ? StDone : StPost;
        end
      end
      StPost: begin
        if (axiValid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == post_eff_q) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; any beat this cycle has still been written.
    if (abortStrobe) begin
      state_d = StIdle;
    end

    busy_d = (state_d == StPrefill) || (state_d == StWaitTrig) || (state_d == StPost);
    done_d = (state_d == StDone);
  end

  // Capture FSM and registered status outputs.
  always_ff @(posedge adcClk or negedge adcReset_n) begin
    if (!adcReset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pre_eff_q    <= '0;
      post_eff_q   <= '0;
      wr_addr_q    <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_eff_q    <= pre_eff_d;
      post_eff_q   <= post_eff_d;
      wr_addr_q    <= wr_addr_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign wrEnable       = wr_en;
  assign wrAddress      = wr_addr_q;
  assign triggerAddress = trig_addr_q;
  assign startAddress   = start_addr_q;
  assign state          = state_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
